// File: rtl/mips32_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS32 control path: FSM states,
// opcode/funct encodings, ALU codes, datapath mux encodings and the
// per-state control word.
package mips32_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    REX,
    RWB,
    AEX,
    AWB,
    BRANCH,
    JUMP
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operation select
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand mux
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Control outputs that depend only on the state (plus the latched funct
  // for REX). Handshake-qualified strobes are produced outside this word.
  typedef struct packed {
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Control word to present while sitting in state s
  function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] rex_alu);
    ctrl_t c;
    c = CTRL_NONE;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_ctrl  = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_ctrl  = ALU_ADD;
      end
      MEMADR, AEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_ctrl  = ALU_ADD;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      REX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_ctrl  = rex_alu;
      end
      RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      AWB: begin
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_ctrl  = ALU_SUB;
        c.pc_src    = PCSRC_ALUOUT;
      end
      JUMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
      default: c = CTRL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips32_alu_decoder.sv
// R-type funct to ALU operation decoder, shared with the single-cycle core.
// valid is low for any funct the datapath cannot execute.
module mips32_alu_decoder
  import mips32_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       valid
);

  // Map funct onto the ALU operation; unknown codes flag invalid
  always_comb begin
    alu_ctrl = ALU_AND;
    valid    = 1'b1;
    case (funct)
      FUNCT_ADD: alu_ctrl = ALU_ADD;
      FUNCT_SUB: alu_ctrl = ALU_SUB;
      FUNCT_AND: alu_ctrl = ALU_AND;
      FUNCT_OR:  alu_ctrl = ALU_OR;
      FUNCT_SLT: alu_ctrl = ALU_SLT;
      default:   valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips32_multicycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS32 datapath. State-only control
// bits are registered from the next state so they line up with the state
// register; strobes qualified by mem_ready, zero or the decoded opcode are
// combinational on top of the current state.
module mips32_multicycle_ctrl
  import mips32_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter bit          SUPPORT_ADDI = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_ctrl,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_reg;
  state_t           state_next;
  ctrl_t            ctrl_reg;
  logic [CNT_W-1:0] count_reg;
  logic             illegal_next;
  logic             retire_next;
  logic [2:0]       rex_alu;
  logic             funct_ok;

  mips32_alu_decoder u_alu_dec (
    .funct    (funct),
    .alu_ctrl (rex_alu),
    .valid    (funct_ok)
  );

  // Next-state, illegal-instruction and retirement decode
  always_comb begin
    state_next   = state_reg;
    illegal_next = 1'b0;
    retire_next  = 1'b0;
    case (state_reg)
      IDLE:   state_next = FETCH;
      FETCH:  if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_next = REX;
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          OP_ADDI: begin
            if (SUPPORT_ADDI) begin
              state_next = AEX;
            end else begin
              state_next   = FETCH;
              illegal_next = 1'b1;
            end
          end
          default: begin
            state_next   = FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end
      MEMADR: state_next = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready) state_next = MEMWB;
      MEMWB: begin
        state_next  = FETCH;
        retire_next = 1'b1;
      end
      MEMWR: begin
        if (mem_ready) begin
          state_next  = FETCH;
          retire_next = 1'b1;
        end
      end
      REX: begin
        if (funct_ok) begin
          state_next = RWB;
        end else begin
          state_next   = FETCH;
          illegal_next = 1'b1;
        end
      end
      AEX: state_next = AWB;
      RWB, AWB, BRANCH, JUMP: begin
        state_next  = FETCH;
        retire_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, registered control word and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ctrl_reg  <= CTRL_NONE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= state_ctrl(state_next, rex_alu);
      if (retire_next) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign ir_write   = !reset && (state_reg == FETCH) && mem_ready;
  assign pc_write   = !reset && (ctrl_reg.pc_write
                                 || ((state_reg == FETCH) && mem_ready)
                                 || ((state_reg == BRANCH) && zero));
  assign illegal_op = !reset && illegal_next;

  assign iord        = ctrl_reg.iord;
  assign mem_read    = ctrl_reg.mem_read;
  assign mem_write   = ctrl_reg.mem_write;
  assign reg_write   = ctrl_reg.reg_write;
  assign reg_dst     = ctrl_reg.reg_dst;
  assign mem_to_reg  = ctrl_reg.mem_to_reg;
  assign alu_src_a   = ctrl_reg.alu_src_a;
  assign alu_src_b   = ctrl_reg.alu_src_b;
  assign pc_src      = ctrl_reg.pc_src;
  assign alu_ctrl    = ctrl_reg.alu_ctrl;
  assign instr_count = count_reg;

endmodule
